branch_target_buffer: RTL and testbench
=======================================

# branch_target_buffer

Branch target buffer that consumes the `BTUpdate` stream emitted by the integer ALU on taken-but-unpredicted branches. It stores branch source → target mappings and answers one fetch-PC lookup per cycle with a registered hit, target and branch kind. It sits between the ALU branch-resolution path and the fetch/branch-predict stage. It is 2-way set-associative with per-set LRU, full tags, and a counter-driven invalidate walk on reset and on clear.

## Interface
- `NUM_SETS`, 32: number of sets; power of two, ≥2.
- `IDX_W`, `$clog2(NUM_SETS)`: index width (derived).
- `TAG_W`, `30-IDX_W`: stored tag width, `pc[31:IDX_W+2]`.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-low.
- `IN_clear` in 1: invalidate all entries (fence.i / context switch).
- `IN_pcValid` in 1: lookup request this cycle.
- `IN_pc` in 32: fetch PC, halfword aligned.
- `IN_upValid` in 1: update write request (`BTUpdate.valid`).
- `IN_upSrc` in 32: branch source address (last halfword of the branch).
- `IN_upDst` in 32: branch target.
- `IN_upIsJump` in 1: unconditional jump (JAL).
- `IN_upCompressed` in 1: 16-bit branch.
- `OUT_ready` out 1: high when not invalidating; lookups and updates are accepted only then.
- `OUT_hit` out 1: registered lookup hit.
- `OUT_dstPC` out 32: predicted target.
- `OUT_srcOffs` out 1: `src[1]` of the hitting entry.
- `OUT_isJump` out 1: kind of the hitting entry.
- `OUT_compressed` out 1: size of the hitting entry.

## Operation
- Address split: `idx = pc[IDX_W+1:2]`, `tag = pc[31:IDX_W+2]`, `offs = pc[1]`.
- Entry fields: `valid`, `tag`, `offs`, `dst[31:1]`, `isJump`, `compressed`. Each set also has one LRU bit, which names the way to replace next.
- States:
  - CLEAR: counter `clrIdx` walks sets 0..NUM_SETS-1, one per cycle, zeroing `valid` and LRU. `OUT_ready`=0.
  - IDLE: normal operation. `OUT_ready`=1.
- Transitions:
  - `rst`=0 → CLEAR with `clrIdx`=0.
  - CLEAR at `clrIdx`=NUM_SETS-1 → IDLE.
  - IDLE with `IN_clear` → CLEAR with `clrIdx`=0.
  - `IN_clear` asserted while in CLEAR restarts the walk at `clrIdx`=0.
- Lookup (IDLE, `IN_pcValid`):
  - Way w hits if `valid && tag==tag(IN_pc) && offs>=IN_pc[1]`. The last condition stops a branch located before the fetch PC within the word from hitting.
  - If both ways hit, choose the one with the smaller `offs`; on a tie, way 0.
  - A hit sets the set's LRU bit to the other way.
- Update (IDLE, `IN_upValid`):
  - If a way matches `tag && offs` exactly, overwrite it.
  - Otherwise, if an invalid way exists, write the lowest-numbered invalid way.
  - Otherwise, write the LRU way.
  - After the write, LRU points to the other way.
- Same-set lookup and update in one cycle: the lookup reads the pre-write contents, and the update's LRU write wins.
- Requests while `OUT_ready`=0: updates are dropped, and lookups return `OUT_hit`=0.
- Reset mid-operation: any in-flight lookup result is discarded and the walk restarts.
- `dst` is stored as `[31:1]`; `OUT_dstPC = {dst,1'b0}`.

## Timing
- Lookup latency is 1 cycle: a request at edge N gives its result on the outputs after edge N+1, held until the next lookup edge.
- When there is no hit, `OUT_hit`=0 and the other outputs are 0.
- An update written at edge N is visible to lookups sampled at edge N+1 or later.
- Reset values: `OUT_hit`=0, `OUT_dstPC`=0, `OUT_srcOffs`=0, `OUT_isJump`=0, `OUT_compressed`=0, `OUT_ready`=0.
- The invalidate walk takes exactly NUM_SETS cycles:
  - `OUT_ready` rises NUM_SETS cycles after the first edge with `rst`=0 released.
  - `OUT_ready` rises NUM_SETS cycles after the `IN_clear` edge.
- Throughput: one lookup plus one update per cycle, no stalls in IDLE.

## Test plan
- **Reset walk:** hold `rst`=0 for 3 cycles, then release. Required: `OUT_ready`=0 for 32 cycles, then 1; all outputs 0 throughout.
- **Basic hit:**
  - Update src=0x1000_0042, dst=0x2000_0000, `isJump`=1, `compressed`=1.
  - Lookup 0x1000_0040 next cycle → `OUT_hit`=1, `OUT_dstPC`=0x2000_0000, `OUT_srcOffs`=1, `OUT_isJump`=1.
  - Lookup 0x1000_0044 → no hit.
- **Offset rule:** update src=0x40 (offs 0). Lookup 0x42 → no hit; lookup 0x40 → hit.
- **LRU eviction:**
  - Write A=0x0000_0080, B=0x0100_0080, C=0x0200_0080 (same set, index 0), touching A by lookup before writing C.
  - Required: B is evicted; A and C hit, B misses.
- **Clear mid-walk and clear in IDLE:**
  - Write 4 entries, pulse `IN_clear` → 32 cycles with `OUT_ready`=0, then all 4 lookups miss.
  - A second `IN_clear` at walk cycle 10 extends `OUT_ready`=0 to 10+32 cycles total.
- **Simultaneous same-set access:**
  - Lookup 0x80 and update src=0x80 with new dst=0x300 in the same cycle → that lookup returns the old dst.
  - The next lookup returns 0x300.

Source files
------------

// File: rtl/branch_target_buffer.sv
// -----------------------------------------------------------------------------
// branch_target_buffer
//
// 2-way set-associative branch target buffer. It is filled from the ALU's
// BTUpdate stream (taken-but-unpredicted branches) and answers one fetch-PC
// lookup per cycle with a registered hit/target/kind result.
//
// Each set has one LRU bit that names the way to replace next. A counter-driven
// walk invalidates every set after reset and after IN_clear. OUT_ready is low
// for the whole walk. Lookups and updates are only accepted while OUT_ready=1.
//
// Ports
//   clk, rst          clock; synchronous active-low reset
//   IN_clear          invalidate all entries (fence.i / context switch)
//   IN_pcValid/IN_pc  lookup request, fetch PC (halfword aligned)
//   IN_upValid        update request
//   IN_upSrc          branch source address (last halfword of the branch)
//   IN_upDst          branch target
//   IN_upIsJump       entry kind (unconditional jump)
//   IN_upCompressed   entry size (16-bit branch)
//   OUT_ready         high when not invalidating
//   OUT_hit           registered lookup hit
//   OUT_dstPC         predicted target ({dst[31:1],1'b0})
//   OUT_srcOffs       src[1] of the hitting entry
//   OUT_isJump        kind of the hitting entry
//   OUT_compressed    size of the hitting entry
// -----------------------------------------------------------------------------
module branch_target_buffer #(
  parameter int NUM_SETS = 32,
  parameter int IDX_W    = $clog2(NUM_SETS),
  parameter int TAG_W    = 30 - IDX_W
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        IN_clear,
  input  logic        IN_pcValid,
  input  logic [31:0] IN_pc,
  input  logic        IN_upValid,
  input  logic [31:0] IN_upSrc,
  input  logic [31:0] IN_upDst,
  input  logic        IN_upIsJump,
  input  logic        IN_upCompressed,
  output logic        OUT_ready,
  output logic        OUT_hit,
  output logic [31:0] OUT_dstPC,
  output logic        OUT_srcOffs,
  output logic        OUT_isJump,
  output logic        OUT_compressed
);

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_IDLE  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] clr_idx_q, clr_idx_d;

  // Entry storage. Per-set single-bit fields are packed by way.
  logic [1:0]       valid_q [NUM_SETS];
  logic             lru_q   [NUM_SETS];
  logic [TAG_W-1:0] tag_q   [NUM_SETS][2];
  logic [1:0]       offs_q  [NUM_SETS];
  logic [30:0]      dst_q   [NUM_SETS][2];
  logic [1:0]       jump_q  [NUM_SETS];
  logic [1:0]       comp_q  [NUM_SETS];

  // Registered lookup result
  logic             hit_q;
  logic [31:0]      dst_pc_q;
  logic             src_offs_q;
  logic             is_jump_q;
  logic             compressed_q;

  // Address split
  logic [IDX_W-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0] lk_tag, up_tag;
  logic             lk_offs, up_offs;

  assign lk_idx  = IN_pc[IDX_W+1:2];
  assign lk_tag  = IN_pc[31:IDX_W+2];
  assign lk_offs = IN_pc[1];
  assign up_idx  = IN_upSrc[IDX_W+1:2];
  assign up_tag  = IN_upSrc[31:IDX_W+2];
  assign up_offs = IN_upSrc[1];

  // Bit 0 of every address is meaningless (halfword aligned).
  logic unused_bits;
  assign unused_bits = ^{IN_pc[0], IN_upSrc[0], IN_upDst[0]};

  logic lk_fire, up_fire;
  assign lk_fire = rst && (state_q == S_IDLE) && IN_pcValid;
  assign up_fire = rst && (state_q == S_IDLE) && IN_upValid;

  // ---------------------------------------------------------------------------
  // Per-way compare
  // ---------------------------------------------------------------------------
  logic [1:0] lk_way_hit;
  logic [1:0] up_way_match;

  for (genvar gi = 0; gi < 2; gi++) begin : g_way
    // offs >= pc[1]: a branch located before the fetch PC within the word
    // has already been passed and must not redirect this fetch.
    assign lk_way_hit[gi]   = valid_q[lk_idx][gi]
                           && (tag_q[lk_idx][gi] == lk_tag)
                           && (offs_q[lk_idx][gi] || !lk_offs);
    assign up_way_match[gi] = valid_q[up_idx][gi]
                           && (tag_q[up_idx][gi] == up_tag)
                           && (offs_q[up_idx][gi] == up_offs);
  end

  logic lk_any;
  logic lk_sel;
  assign lk_any = |lk_way_hit;
  // With two hits the earlier branch in the word (smaller offs) wins;
  // equal offsets fall back to way 0.
  assign lk_sel = lk_way_hit[1]
               && (!lk_way_hit[0] || (!offs_q[lk_idx][1] && offs_q[lk_idx][0]));

  // Replacement choice: exact match, then lowest invalid way, then LRU.
  logic up_way;
  always_comb begin
    up_way = lru_q[up_idx];
    if (|up_way_match) begin
      up_way = !up_way_match[0];
    end else if (!valid_q[up_idx][0]) begin
      up_way = 1'b0;
    end else if (!valid_q[up_idx][1]) begin
      up_way = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Invalidate-walk FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_CLEAR;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    case (state_q)
      S_CLEAR: begin
        if (IN_clear) begin
          clr_idx_d = '0;
        end else if (clr_idx_q == IDX_W'(NUM_SETS - 1)) begin
          state_d   = S_IDLE;
          clr_idx_d = '0;
        end else begin
          clr_idx_d = clr_idx_q + IDX_W'(1);
        end
      end
      S_IDLE: begin
        if (IN_clear) begin
          state_d   = S_CLEAR;
          clr_idx_d = '0;
        end
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Valid / LRU state. The update's LRU write comes last so it wins over a
  // same-set lookup touch in the same cycle.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (state_q == S_CLEAR) begin
      valid_q[clr_idx_q] <= 2'b00;
      lru_q[clr_idx_q]   <= 1'b0;
    end else begin
      if (lk_fire && lk_any) begin
        lru_q[lk_idx] <= !lk_sel;
      end
      if (up_fire) begin
        valid_q[up_idx][up_way] <= 1'b1;
        lru_q[up_idx]           <= !up_way;
      end
    end
  end

  // Entry payload; no reset needed since valid gates every use.
  always_ff @(posedge clk) begin
    if (up_fire) begin
      tag_q[up_idx][up_way]  <= up_tag;
      offs_q[up_idx][up_way] <= up_offs;
      dst_q[up_idx][up_way]  <= IN_upDst[31:1];
      jump_q[up_idx][up_way] <= IN_upIsJump;
      comp_q[up_idx][up_way] <= IN_upCompressed;
    end
  end

  // ---------------------------------------------------------------------------
  // Registered lookup result, held until the next lookup request.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      hit_q        <= 1'b0;
      dst_pc_q     <= '0;
      src_offs_q   <= 1'b0;
      is_jump_q    <= 1'b0;
      compressed_q <= 1'b0;
    end else if (lk_fire) begin
      hit_q        <= lk_any;
      dst_pc_q     <= lk_any ? {dst_q[lk_idx][lk_sel], 1'b0} : 32'd0;
      src_offs_q   <= lk_any && offs_q[lk_idx][lk_sel];
      is_jump_q    <= lk_any && jump_q[lk_idx][lk_sel];
      compressed_q <= lk_any && comp_q[lk_idx][lk_sel];
    end else if (IN_pcValid) begin
      // Lookup during the walk: answered as a miss.
      hit_q        <= 1'b0;
      dst_pc_q     <= '0;
      src_offs_q   <= 1'b0;
      is_jump_q    <= 1'b0;
      compressed_q <= 1'b0;
    end
  end

  assign OUT_ready      = (state_q == S_IDLE);
  assign OUT_hit        = hit_q;
  assign OUT_dstPC      = dst_pc_q;
  assign OUT_srcOffs    = src_offs_q;
  assign OUT_isJump     = is_jump_q;
  assign OUT_compressed = compressed_q;

endmodule

// File: tb/tb_branch_target_buffer.sv
// -----------------------------------------------------------------------------
// tb_branch_target_buffer
//
// Directed scenarios followed by randomized traffic. A behavioural model keeps
// each entry as its full source address and is stepped on every rising edge.
// One compare task runs on every falling edge and checks all DUT outputs
// against the model. Literal checks pin the directed scenarios.
// -----------------------------------------------------------------------------
module tb_branch_target_buffer;

  localparam int NUM_SETS = 32;

  logic        clk;
  logic        rst;
  logic        IN_clear;
  logic        IN_pcValid;
  logic [31:0] IN_pc;
  logic        IN_upValid;
  logic [31:0] IN_upSrc;
  logic [31:0] IN_upDst;
  logic        IN_upIsJump;
  logic        IN_upCompressed;
  logic        OUT_ready;
  logic        OUT_hit;
  logic [31:0] OUT_dstPC;
  logic        OUT_srcOffs;
  logic        OUT_isJump;
  logic        OUT_compressed;

  branch_target_buffer #(.NUM_SETS(NUM_SETS)) dut (
    .clk             (clk),
    .rst             (rst),
    .IN_clear        (IN_clear),
    .IN_pcValid      (IN_pcValid),
    .IN_pc           (IN_pc),
    .IN_upValid      (IN_upValid),
    .IN_upSrc        (IN_upSrc),
    .IN_upDst        (IN_upDst),
    .IN_upIsJump     (IN_upIsJump),
    .IN_upCompressed (IN_upCompressed),
    .OUT_ready       (OUT_ready),
    .OUT_hit         (OUT_hit),
    .OUT_dstPC       (OUT_dstPC),
    .OUT_srcOffs     (OUT_srcOffs),
    .OUT_isJump      (OUT_isJump),
    .OUT_compressed  (OUT_compressed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------------------------------------------------------------------
  // Behavioural model: entries hold the full source address; an entry serves
  // a fetch PC when the word addresses agree and the branch is not before it.
  // ---------------------------------------------------------------------------
  bit          m_valid  [NUM_SETS][2];
  logic [31:0] m_src    [NUM_SETS][2];
  logic [31:0] m_dst    [NUM_SETS][2];
  bit          m_jmp    [NUM_SETS][2];
  bit          m_cmp    [NUM_SETS][2];
  int          m_victim [NUM_SETS];
  int          m_walk = NUM_SETS;   // rising edges still needed before ready

  logic        e_ready = 1'b0;
  logic        e_hit   = 1'b0;
  logic [31:0] e_dst   = '0;
  logic        e_offs  = 1'b0;
  logic        e_jmp   = 1'b0;
  logic        e_cmp   = 1'b0;

  function automatic void wipe();
    for (int s = 0; s < NUM_SETS; s++) begin
      m_valid[s][0] = 0;
      m_valid[s][1] = 0;
      m_victim[s]   = 0;
    end
  endfunction

  function automatic void zero_result();
    e_hit  = 1'b0;
    e_dst  = '0;
    e_offs = 1'b0;
    e_jmp  = 1'b0;
    e_cmp  = 1'b0;
  endfunction

  always @(posedge clk) begin : p_model
    int   s, u, h, w;
    bit   hv0, hv1, lk_hit;
    if (!rst) begin
      wipe();
      zero_result();
      m_walk = NUM_SETS;
    end else if (m_walk > 0) begin
      if (IN_pcValid) zero_result();
      m_walk = IN_clear ? NUM_SETS : m_walk - 1;
    end else begin
      // Both requests see the state from before this edge.
      lk_hit = 0;
      h      = 0;
      s      = int'((IN_pc >> 2) % NUM_SETS);
      if (IN_pcValid) begin
        hv0 = m_valid[s][0] && (m_src[s][0][31:2] == IN_pc[31:2]) && (m_src[s][0][1] >= IN_pc[1]);
        hv1 = m_valid[s][1] && (m_src[s][1][31:2] == IN_pc[31:2]) && (m_src[s][1][1] >= IN_pc[1]);
        lk_hit = hv0 || hv1;
        if (hv0 && hv1) h = (m_src[s][1][1] < m_src[s][0][1]) ? 1 : 0;
        else            h = hv0 ? 0 : 1;
        if (lk_hit) begin
          e_hit  = 1'b1;
          e_dst  = m_dst[s][h];
          e_offs = m_src[s][h][1];
          e_jmp  = m_jmp[s][h];
          e_cmp  = m_cmp[s][h];
        end else begin
          zero_result();
        end
      end
      u = int'((IN_upSrc >> 2) % NUM_SETS);
      if (m_valid[u][0] && m_src[u][0][31:1] == IN_upSrc[31:1])      w = 0;
      else if (m_valid[u][1] && m_src[u][1][31:1] == IN_upSrc[31:1]) w = 1;
      else if (!m_valid[u][0])                                      w = 0;
      else if (!m_valid[u][1])                                      w = 1;
      else                                                          w = m_victim[u];
      if (lk_hit) m_victim[s] = 1 - h;
      if (IN_upValid) begin
        m_valid[u][w] = 1;
        m_src[u][w]   = IN_upSrc;
        m_dst[u][w]   = {IN_upDst[31:1], 1'b0};
        m_jmp[u][w]   = IN_upIsJump;
        m_cmp[u][w]   = IN_upCompressed;
        m_victim[u]   = 1 - w;
      end
      if (IN_clear) begin
        wipe();
        m_walk = NUM_SETS;
      end
    end
    e_ready = (m_walk == 0);
  end

  // ---------------------------------------------------------------------------
  // Compare process: one falling-edge step, checking the DUT against the model.
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(negedge clk);
    n_cmp++;
    if (OUT_ready !== e_ready || OUT_hit !== e_hit || OUT_dstPC !== e_dst ||
        OUT_srcOffs !== e_offs || OUT_isJump !== e_jmp || OUT_compressed !== e_cmp) begin
      n_bad++;
      $display("FAIL model_cycle t=%0t got rdy=%0b hit=%0b dst=%h offs=%0b jmp=%0b cmp=%0b expected rdy=%0b hit=%0b dst=%h offs=%0b jmp=%0b cmp=%0b",
               $time, OUT_ready, OUT_hit, OUT_dstPC, OUT_srcOffs, OUT_isJump, OUT_compressed,
               e_ready, e_hit, e_dst, e_offs, e_jmp, e_cmp);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic do_update(input logic [31:0] src, input logic [31:0] dst, input logic j, input logic c);
    IN_upValid = 1'b1; IN_upSrc = src; IN_upDst = dst; IN_upIsJump = j; IN_upCompressed = c;
    tick();
    IN_upValid = 1'b0;
  endtask

  task automatic do_lookup(input logic [31:0] pc);
    IN_pcValid = 1'b1; IN_pc = pc;
    tick();
    IN_pcValid = 1'b0;
  endtask

  // Counts falling edges with OUT_ready low, starting with the current one.
  task automatic count_not_ready(inout int z);
    int guard;
    guard = 0;
    while (!OUT_ready && guard < 200) begin
      z++; guard++;
      tick();
    end
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] r;
    r = $urandom;
    if (r[3:0] != 4'd0)
      return (32'($urandom_range(0, 3)) << 7) | (32'($urandom_range(0, 2)) << 2)
           | (32'(r[4]) << 1) | (32'(r[5]) << 31);
    return $urandom;
  endfunction

  initial begin : p_stim
    int z;
    logic [31:0] four [4];
    rst = 1'b0; IN_clear = 1'b0; IN_pcValid = 1'b0; IN_pc = '0;
    IN_upValid = 1'b0; IN_upSrc = '0; IN_upDst = '0; IN_upIsJump = 1'b0; IN_upCompressed = 1'b0;

    // Reset walk
    repeat (3) tick();
    chk("reset_ready", 32'(OUT_ready), 32'd0);
    rst = 1'b1;
    z = 0; count_not_ready(z);
    chk("reset_walk_len", z, 32'd32);

    // Basic hit
    do_update(32'h1000_0042, 32'h2000_0000, 1'b1, 1'b1);
    do_lookup(32'h1000_0040);
    chk("basic_hit",    32'(OUT_hit),        32'd1);
    chk("basic_dst",    OUT_dstPC,           32'h2000_0000);
    chk("basic_offs",   32'(OUT_srcOffs),    32'd1);
    chk("basic_jump",   32'(OUT_isJump),     32'd1);
    chk("basic_cmp",    32'(OUT_compressed), 32'd1);
    do_lookup(32'h1000_0044);
    chk("basic_miss",   32'(OUT_hit),        32'd0);
    chk("basic_miss_dst", OUT_dstPC,         32'd0);

    // Offset rule
    do_update(32'h0000_0040, 32'h0000_0500, 1'b0, 1'b0);
    do_lookup(32'h0000_0042);
    chk("offs_after_miss", 32'(OUT_hit), 32'd0);
    do_lookup(32'h0000_0040);
    chk("offs_same_hit",   32'(OUT_hit), 32'd1);
    chk("offs_same_dst",   OUT_dstPC,    32'h0000_0500);

    // Clear in IDLE
    four[0] = 32'h1000_0042; four[1] = 32'h0000_0040; four[2] = 32'h0000_1000; four[3] = 32'h0000_2004;
    do_update(four[2], 32'h0000_0700, 1'b0, 1'b1);
    do_update(four[3], 32'h0000_0800, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      do_lookup(four[i]);
      chk($sformatf("preclear_hit%0d", i), 32'(OUT_hit), 32'd1);
    end
    IN_clear = 1'b1; tick(); IN_clear = 1'b0;
    z = 0; count_not_ready(z);
    chk("clear_walk_len", z, 32'd32);
    for (int i = 0; i < 4; i++) begin
      do_lookup(four[i]);
      chk($sformatf("postclear_miss%0d", i), 32'(OUT_hit), 32'd0);
    end

    // Second clear at walk cycle 10
    IN_clear = 1'b1; tick(); IN_clear = 1'b0;
    z = 0;
    repeat (9) begin
      if (!OUT_ready) z++;
      tick();
    end
    IN_clear = 1'b1;
    if (!OUT_ready) z++;
    tick();
    IN_clear = 1'b0;
    count_not_ready(z);
    chk("reclear_walk_len", z, 32'd42);

    // LRU eviction: A, B, touch A, C -> B evicted
    do_update(32'h0000_0080, 32'h0000_0A00, 1'b0, 1'b0);
    do_update(32'h0100_0080, 32'h0000_0B00, 1'b0, 1'b0);
    do_lookup(32'h0000_0080);
    chk("lru_touch_a", 32'(OUT_hit), 32'd1);
    do_update(32'h0200_0080, 32'h0000_0C00, 1'b0, 1'b0);
    do_lookup(32'h0000_0080);
    chk("lru_a_dst", OUT_dstPC, 32'h0000_0A00);
    do_lookup(32'h0200_0080);
    chk("lru_c_dst", OUT_dstPC, 32'h0000_0C00);
    do_lookup(32'h0100_0080);
    chk("lru_b_miss", 32'(OUT_hit), 32'd0);

    // Same-set lookup and update in one cycle
    IN_pcValid = 1'b1; IN_pc = 32'h0000_0080;
    IN_upValid = 1'b1; IN_upSrc = 32'h0000_0080; IN_upDst = 32'h0000_0300;
    IN_upIsJump = 1'b0; IN_upCompressed = 1'b0;
    tick();
    IN_pcValid = 1'b0; IN_upValid = 1'b0;
    chk("simul_old_dst", OUT_dstPC, 32'h0000_0A00);
    do_lookup(32'h0000_0080);
    chk("simul_new_dst", OUT_dstPC, 32'h0000_0300);

    // Randomized traffic
    for (int k = 0; k < 4000; k++) begin
      rst             = ($urandom_range(0, 599) != 0);
      IN_clear        = ($urandom_range(0, 299) == 0);
      IN_pcValid      = 1'($urandom_range(0, 1));
      IN_pc           = rand_addr();
      IN_upValid      = ($urandom_range(0, 9) < 4);
      IN_upSrc        = rand_addr();
      IN_upDst        = $urandom;
      IN_upIsJump     = 1'($urandom_range(0, 1));
      IN_upCompressed = 1'($urandom_range(0, 1));
      tick();
    end
    rst = 1'b1; IN_clear = 1'b0; IN_pcValid = 1'b0; IN_upValid = 1'b0;
    repeat (40) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
